// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_ctrl
//  Function : Accepts a WORD_W-bit word over a valid/ready handshake, shifts it
//             MSB-first through an embedded run-length detector (RUN_LEN equal
//             consecutive bits = hit), counts hits and reports the hit count
//             and first-hit bit index over a second valid/ready handshake.
//  Options  : SEQ_CTRL_STICKY_EN - when defined, detector history (run count
//             and last bit) survives word accepts and is cleared only by
//             reset, so runs may continue across consecutive words.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
  parameter int WORD_W  = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          out_hits,
  output logic [$clog2(WORD_W)-1:0] out_first,
  output logic                      hit,
  output logic [1:0]                state_dbg
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int RUN_W = 4;

  localparam logic [1:0]       c_st_idle   = 2'd0;
  localparam logic [1:0]       c_st_shift  = 2'd1;
  localparam logic [1:0]       c_st_report = 2'd2;

  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);
  localparam logic [RUN_W-1:0] c_run_max   = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] c_run_one   = RUN_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  hits_q,  hits_d;
  logic [IDX_W-1:0]  first_q, first_d;
  logic              found_q, found_d;
  logic [RUN_W-1:0]  run_q,   run_d;
  logic              prev_q,  prev_d;
  logic              hist_q,  hist_d;

  logic              w_accept;
  logic              w_bit;
  logic [RUN_W-1:0]  w_run_upd;
  logic              w_hit;

  // FSM state register; state 3 is unreachable and falls back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:   if (in_valid)            state_d = c_st_shift;
      c_st_shift:  if (idx_q == c_last_idx) state_d = c_st_report;
      c_st_report: if (out_ready)           state_d = c_st_idle;
      default:                              state_d = c_st_idle;
    endcase
  end

  // FSM outputs: handshakes and LED debug encoding
  always_comb begin
    in_ready  = (state_q == c_st_idle);
    out_valid = (state_q == c_st_report);
    state_dbg = state_q;
  end

  // Detector: run length after taking the current MSB; saturates at RUN_LEN
  // so a long run keeps producing a hit on every further equal bit
  always_comb begin
    w_accept = (state_q == c_st_idle) && in_valid;
    w_bit    = shreg_q[WORD_W-1];
    if (!hist_q || (w_bit != prev_q)) begin
      w_run_upd = c_run_one;
    end else if (run_q == c_run_max) begin
      w_run_upd = c_run_max;
    end else begin
      w_run_upd = run_q + c_run_one;
    end
    w_hit = (state_q == c_st_shift) && (w_run_upd == c_run_max);
  end

  // Datapath next-state: load on accept, shift/count while scanning
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    hits_d  = hits_q;
    first_d = first_q;
    found_d = found_q;
    run_d   = run_q;
    prev_d  = prev_q;
    hist_d  = hist_q;
    if (w_accept) begin
      shreg_d = in_data;
      idx_d   = '0;
      hits_d  = '0;
      first_d = '0;
      found_d = 1'b0;
`ifdef SEQ_CTRL_STICKY_EN
      // history carried over so runs may straddle consecutive words
`else
      run_d   = '0;
      prev_d  = 1'b0;
      hist_d  = 1'b0;
`endif
    end else if (state_q == c_st_shift) begin
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      idx_d   = idx_q + c_idx_one;
      run_d   = w_run_upd;
      prev_d  = w_bit;
      hist_d  = 1'b1;
      if (w_hit) begin
        if (hits_q != c_cnt_max) begin
          hits_d = hits_q + c_cnt_one;
        end
        if (!found_q) begin
          first_d = idx_q;
          found_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
      hits_q  <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      run_q   <= '0;
      prev_q  <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      first_q <= first_d;
      found_q <= found_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      hist_q  <= hist_d;
    end
  end

  // Report values held in registers so they stay stable under backpressure
  always_comb begin
    out_hits  = hits_q;
    out_first = first_q;
    hit       = w_hit;
  end

endmodule
`default_nettype wire
